sysbus_arbiter: RTL
===================

# sysbus_arbiter

Single-owner arbiter and sequencer for the core's one Sysbus port. Three internal clients issue 64-byte line reads: page-table walker (ptw), data memory (dmem) and instruction fetch (imem). The block grants one client at a time, drives the request phase, acknowledges the 8 response beats, and routes each beat back to the owning client. It sits between the fetch/PTW/LSU logic and the top-level bus pins.

## Interface
Parameters:
- BUS_DATA_WIDTH, 64, bus data width
- BUS_TAG_WIDTH, 13, bus tag width
- BEATS, 8, response beats per line (64 B / 8 B)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ptw_req, dmem_req, imem_req  in  1 each  client request valid; held until its grant
- ptw_addr, dmem_addr, imem_addr  in  64 each  client byte address
- ptw_gnt, dmem_gnt, imem_gnt  out  1 each  one-cycle grant pulse; address is captured
- resp_data  out  BUS_DATA_WIDTH  current beat, broadcast to all clients
- resp_beat  out  3  beat index 0..7
- resp_last  out  1  high with beat 7
- ptw_resp_valid, dmem_resp_valid, imem_resp_valid  out  1 each  beat valid for that client
- busy  out  1  high in REQ or RESP
- err  out  1  sticky; stray or mis-tagged beat seen
- bus_reqcyc  out  1  request valid
- bus_req  out  BUS_DATA_WIDTH  line-aligned address
- bus_reqtag  out  BUS_TAG_WIDTH  request tag
- bus_reqack  in  1  request accepted
- bus_respcyc  in  1  response beat valid
- bus_resp  in  BUS_DATA_WIDTH  response data
- bus_resptag  in  BUS_TAG_WIDTH  response tag
- bus_respack  out  1  beat acknowledge

## Operation
- States: IDLE, REQ, RESP.
- IDLE arbitration is combinational. ptw has fixed highest priority. dmem and imem alternate round-robin through a 1-bit pointer that records the last served of the two. The pointer updates only when dmem or imem is granted. After reset, dmem wins the first dmem/imem tie.
- In IDLE with any request: the winner's gnt is high this cycle. The arbiter latches owner id and {addr[63:6],6'b0}, and the next state is REQ.
- REQ: bus_reqcyc=1, bus_req=latched address, bus_reqtag = `SYSBUS_READ<<12 | `SYSBUS_MEMORY<<8 | owner id in [1:0] (ptw=0, dmem=1, imem=2). These hold stable until bus_reqack is sampled high. Then the next state is RESP and bus_reqcyc drops.
- RESP: bus_respack = bus_respcyc, combinational, in the same cycle.
  - Beat with resptag[1:0]==owner: assert X_resp_valid for the owner and increment the 3-bit beat counter. resp_data=bus_resp, resp_beat=counter.
  - Beat with resptag[1:0]!=owner: ack it, drop it, set err, do not count it.
  - Gaps (respcyc low) are allowed without limit.
  - The accepted beat with counter==7 asserts resp_last. The next state is IDLE and the counter wraps to 0.
- IDLE or REQ with bus_respcyc high: stray beat. Ack it, drop it, set err. No resp_valid is asserted.
- Only one transaction is outstanding. Requests arriving while busy wait.

## Timing
- Reset values: state IDLE, bus_reqcyc 0, bus_req 0, bus_reqtag 0, bus_respack 0, all gnt 0, all resp_valid 0, resp_beat 0, resp_last 0, busy 0, err 0, rr pointer = imem.
- Reset mid-REQ or mid-RESP abandons the transaction: everything returns to reset values the next cycle. Late beats from the abandoned transaction are then handled as strays (acked, err set).
- Latency:
  - req-to-gnt: 0 cycles in IDLE.
  - gnt-to-bus_reqcyc: 1 cycle.
  - reqack cycle to RESP: 1 cycle.
  - beat-to-resp_valid: 0 cycles.
  - last beat to next gnt: 1 cycle minimum.
- Back-to-back minimum per line: 1 (IDLE) + 1 (REQ with immediate ack) + 8 beats = 10 cycles.
- busy is high exactly in REQ and RESP.

## Test plan
- Single imem read, addr 0x1000_0044, reqack on the first REQ cycle, 8 consecutive beats -> imem_gnt pulses in cycle 0; bus_req=0x1000_0040; tag low bits=2; imem_resp_valid for 8 cycles with resp_beat 0..7; resp_last on beat 7; back in IDLE after the last beat.
- ptw, dmem and imem all requesting in the same cycle -> order ptw, dmem, imem. Repeating with dmem+imem held continuously -> strict alternation dmem, imem, dmem, imem.
- bus_reqack withheld 5 cycles -> bus_reqcyc, bus_req and bus_reqtag stable for 5 cycles; RESP is entered only after the ack.
- Beats with 3-cycle gaps between them -> bus_respack only on respcyc cycles; beat index continuous 0..7.
- Stray beat in IDLE, then a mis-tagged beat (resptag[1:0]=1 while owner is 0) in RESP -> both acked, no resp_valid for either, err set and held until reset; the transaction still completes after 8 correct beats.
- reset asserted after beat 3 of a dmem read -> next cycle IDLE with every output at its reset value; remaining beats acked as strays; a new imem request is then granted normally.

Source files
------------

// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: single-owner arbiter and sequencer for the core's Sysbus port.
// Grants one of three line-read clients (ptw > round-robin{dmem, imem}), issues
// the tagged request, acknowledges the response beats and routes each matching
// beat back to the owner. Beats that are stray or carry the wrong tag are acked,
// dropped, and latched into a sticky err flag.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   *_req / *_addr / *_gnt      client request, byte address, one-cycle grant
//   resp_data/beat/last         broadcast beat data, index, final-beat flag
//   *_resp_valid                beat valid for that client
//   busy, err                   transaction in flight; sticky bad-beat flag
//   bus_req*                    request phase toward the bus
//   bus_resp*, bus_respack      response phase from the bus, beat acknowledge

`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

module sysbus_arbiter #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int BEATS          = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ptw_req,
   input  logic                      dmem_req,
   input  logic                      imem_req,
   input  logic [63:0]               ptw_addr,
   input  logic [63:0]               dmem_addr,
   input  logic [63:0]               imem_addr,
   output logic                      ptw_gnt,
   output logic                      dmem_gnt,
   output logic                      imem_gnt,
   output logic [BUS_DATA_WIDTH-1:0] resp_data,
   output logic [2:0]                resp_beat,
   output logic                      resp_last,
   output logic                      ptw_resp_valid,
   output logic                      dmem_resp_valid,
   output logic                      imem_resp_valid,
   output logic                      busy,
   output logic                      err,
   output logic                      bus_reqcyc,
   output logic [BUS_DATA_WIDTH-1:0] bus_req,
   output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   input  logic                      bus_reqack,
   input  logic                      bus_respcyc,
   input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
   output logic                      bus_respack
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

   localparam logic [1:0] ID_PTW  = 2'd0;
   localparam logic [1:0] ID_DMEM = 2'd1;
   localparam logic [1:0] ID_IMEM = 2'd2;
   localparam int         TAG_RD  = `SYSBUS_READ;
   localparam int         TAG_MEM = `SYSBUS_MEMORY;
   localparam logic [BUS_TAG_WIDTH-1:0] TAG_BASE =
      BUS_TAG_WIDTH'((TAG_RD << 12) | (TAG_MEM << 8));
   localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

   state_t      r_state, w_next;
   logic [1:0]  r_owner;
   logic [63:0] r_addr;
   logic [2:0]  r_beat;
   logic        r_rr_imem;   // 1: imem was the last of dmem/imem served
   logic        r_err;

   logic        w_any;
   logic [1:0]  w_win;
   logic [63:0] w_win_addr;
   logic        w_match;
   logic        w_stray;
   logic        w_unused;

   // Address offset bits and upper tag bits are intentionally ignored.
   assign w_unused = &{1'b0, ptw_addr[5:0], dmem_addr[5:0], imem_addr[5:0],
                       bus_resptag[BUS_TAG_WIDTH-1:2]};

   // Arbitration: ptw first; a dmem/imem tie goes to whichever was not served last.
   always_comb begin
      w_any      = ptw_req | dmem_req | imem_req;
      w_win      = ID_PTW;
      w_win_addr = ptw_addr;
      if (ptw_req) begin
         w_win = ID_PTW;
      end else if (dmem_req && imem_req) begin
         w_win = r_rr_imem ? ID_DMEM : ID_IMEM;
      end else if (dmem_req) begin
         w_win = ID_DMEM;
      end else if (imem_req) begin
         w_win = ID_IMEM;
      end
      case (w_win)
         ID_DMEM: w_win_addr = dmem_addr;
         ID_IMEM: w_win_addr = imem_addr;
         default: w_win_addr = ptw_addr;
      endcase
   end

   always_comb begin
      w_next          = r_state;
      ptw_gnt         = 1'b0;
      dmem_gnt        = 1'b0;
      imem_gnt        = 1'b0;
      ptw_resp_valid  = 1'b0;
      dmem_resp_valid = 1'b0;
      imem_resp_valid = 1'b0;
      resp_last       = 1'b0;
      bus_respack     = 1'b0;
      w_match         = 1'b0;
      w_stray         = 1'b0;
      if (!reset) begin
         // Every beat is acknowledged, whether or not it is wanted.
         bus_respack = bus_respcyc;
         case (r_state)
            S_IDLE: begin
               w_stray = bus_respcyc;
               if (w_any) begin
                  w_next = S_REQ;
                  case (w_win)
                     ID_PTW:  ptw_gnt  = 1'b1;
                     ID_DMEM: dmem_gnt = 1'b1;
                     ID_IMEM: imem_gnt = 1'b1;
                     default: ;
                  endcase
               end
            end
            S_REQ: begin
               w_stray = bus_respcyc;
               if (bus_reqack) w_next = S_RESP;
            end
            S_RESP: begin
               if (bus_respcyc) begin
                  if (bus_resptag[1:0] == r_owner) begin
                     w_match = 1'b1;
                     case (r_owner)
                        ID_PTW:  ptw_resp_valid  = 1'b1;
                        ID_DMEM: dmem_resp_valid = 1'b1;
                        ID_IMEM: imem_resp_valid = 1'b1;
                        default: ;
                     endcase
                     if (r_beat == LAST_BEAT) begin
                        resp_last = 1'b1;
                        w_next    = S_IDLE;
                     end
                  end else begin
                     w_stray = 1'b1;
                  end
               end
            end
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_owner   <= ID_PTW;
         r_addr    <= '0;
         r_beat    <= '0;
         r_rr_imem <= 1'b1;
         r_err     <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && w_any) begin
            r_owner <= w_win;
            r_addr  <= {w_win_addr[63:6], 6'b0};
            if (w_win != ID_PTW) r_rr_imem <= (w_win == ID_IMEM);
         end
         if (w_match) r_beat <= (r_beat == LAST_BEAT) ? 3'd0 : r_beat + 3'd1;
         if (w_stray) r_err <= 1'b1;
      end
   end

   assign busy       = (r_state != S_IDLE);
   assign bus_reqcyc = (r_state == S_REQ);
   assign bus_req    = bus_reqcyc ? BUS_DATA_WIDTH'(r_addr) : '0;
   assign bus_reqtag = bus_reqcyc ? (TAG_BASE | BUS_TAG_WIDTH'(r_owner)) : '0;
   assign resp_data  = bus_resp;
   assign resp_beat  = r_beat;
   assign err        = r_err;

endmodule
